// File: rtl/ctrl_trace_encoder.sv
// Decode->execute trace tap: re-encodes a 30-bit control vector to its opcode and
// buffers {opcode, pc, illegal} in a small FIFO drained through a valid/ready port.
module ctrl_trace_encoder #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [29:0]      in_ctrl,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_opcode,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             clr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + PC_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [4:0] enc_opcode;
  logic       enc_illegal;

  // Only exact canonical patterns map to an opcode; anything else is flagged.
  always_comb begin
    enc_opcode  = 5'b11111;
    enc_illegal = 1'b0;
    case (in_ctrl)
      30'h0000_0000: enc_opcode = 5'b00000;
      30'h0000_0010: enc_opcode = 5'b01111;
      30'h0000_0020: enc_opcode = 5'b01110;
      30'h0000_0040: enc_opcode = 5'b01101;
      30'h0000_0081: enc_opcode = 5'b01000;
      30'h0000_0101: enc_opcode = 5'b01001;
      30'h0000_0201: enc_opcode = 5'b01010;
      30'h0000_0401: enc_opcode = 5'b01011;
      30'h0000_0802: enc_opcode = 5'b01100;
      30'h0000_1004: enc_opcode = 5'b00111;
      30'h0000_2008: enc_opcode = 5'b11010;
      30'h0000_400C: enc_opcode = 5'b00110;
      30'h0000_8002: enc_opcode = 5'b00101;
      30'h0001_0008: enc_opcode = 5'b11001;
      30'h0002_0008: enc_opcode = 5'b11000;
      30'h0004_0008: enc_opcode = 5'b10111;
      30'h0008_0008: enc_opcode = 5'b10110;
      30'h0010_0008: enc_opcode = 5'b10101;
      30'h0020_0008: enc_opcode = 5'b10011;
      30'h0040_0008: enc_opcode = 5'b10010;
      30'h0080_0008: enc_opcode = 5'b00100;
      30'h0100_0000: enc_opcode = 5'b00011;
      30'h0200_0008: enc_opcode = 5'b10001;
      30'h0400_0008: enc_opcode = 5'b10000;
      30'h0800_0008: enc_opcode = 5'b10100;
      30'h1000_0000: enc_opcode = 5'b00010;
      30'h2000_0000: enc_opcode = 5'b00001;
      default:       enc_illegal = 1'b1;
    endcase
  end

  logic [EW-1:0]   mem [0:DEPTH-1];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]     count_reg, count_next;
  logic            out_valid_reg, out_illegal_reg;
  logic [4:0]      out_opcode_reg;
  logic [PC_W-1:0] out_pc_reg;
  logic [CNT_W-1:0] drop_cnt_reg, illegal_cnt_reg;

  logic          full, push, pop, head_load, head_from_input;
  logic [EW-1:0] wr_data, head_next;

  assign full    = (count_reg == FULL_CNT);
  assign push    = in_valid && !full;
  assign pop     = out_valid_reg && out_ready;
  assign wr_data = {enc_opcode, in_pc, enc_illegal};

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (AW + 1)'(1);
    else if (!push && pop)
      count_next = count_reg - (AW + 1)'(1);
  end

  // The head register reloads only when it is consumed or empty, so it holds
  // steady under backpressure. When the FIFO drains to nothing this cycle, the
  // incoming word becomes the new head directly.
  assign rd_ptr_next     = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  assign head_load       = pop || (count_reg == '0);
  assign head_from_input = (count_reg == '0) || (pop && count_reg == (AW + 1)'(1));
  assign head_next       = head_from_input ? wr_data : mem[rd_ptr_next];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      out_valid_reg   <= 1'b0;
      out_opcode_reg  <= '0;
      out_pc_reg      <= '0;
      out_illegal_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      if (head_load && count_next != '0)
        {out_opcode_reg, out_pc_reg, out_illegal_reg} <= head_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg    <= '0;
      illegal_cnt_reg <= '0;
    end else if (clr_cnt) begin
      drop_cnt_reg    <= '0;
      illegal_cnt_reg <= '0;
    end else begin
      if (in_valid && full && drop_cnt_reg != '1)
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      if (push && enc_illegal && illegal_cnt_reg != '1)
        illegal_cnt_reg <= illegal_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_opcode  = out_opcode_reg;
  assign out_pc      = out_pc_reg;
  assign out_illegal = out_illegal_reg;
  assign drop_cnt    = drop_cnt_reg;
  assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Directed bench for ctrl_trace_encoder: a scoreboard queue holds expected
// trace words, pushed when stimulus is accepted and popped when the head drains.
module tb_ctrl_trace_encoder;

  localparam int DEPTH = 8;
  localparam int PC_W  = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [29:0]      in_ctrl;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_opcode;
  logic [PC_W-1:0]  out_pc;
  logic             out_illegal;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] illegal_cnt;
  logic             clr_cnt;

  ctrl_trace_encoder #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_pc(out_pc), .out_illegal(out_illegal), .drop_cnt(drop_cnt),
    .illegal_cnt(illegal_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      op;
    logic [PC_W-1:0] pc;
    logic            ill;
  } exp_t;

  exp_t        q[$];
  logic [29:0] ctab [27];
  logic [4:0]  otab [27];
  int          ntab = 0;
  int          m_drop = 0, m_ill = 0;
  int          pass_cnt = 0, total_cnt = 0;

  // Canonical table built from the "bit plus companion bits" description.
  task automatic add(input int bitn, input logic [3:0] extra, input logic [4:0] op);
    logic [29:0] v;
    v = {26'd0, extra};
    if (bitn >= 0) v = v | (30'd1 << bitn);
    ctab[ntab] = v;
    otab[ntab] = op;
    ntab++;
  endtask

  task automatic model_encode(input logic [29:0] c, output logic [4:0] op, output logic il);
    op = 5'b11111;
    il = 1'b1;
    for (int i = 0; i < ntab; i++)
      if (ctab[i] == c) begin
        op = otab[i];
        il = 1'b0;
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of stimulus: check the head against the scoreboard before the
  // edge, update the model, then check the counters after the edge.
  task automatic step(input logic v, input logic [29:0] c, input logic [PC_W-1:0] p,
                      input logic r, input logic clr);
    logic [4:0] op;
    logic       il;
    int         sz;
    in_valid = v; in_ctrl = c; in_pc = p; out_ready = r; clr_cnt = clr;
    #1;
    sz = q.size();
    chk("out_valid", {31'd0, out_valid}, {31'd0, sz != 0});
    if (sz != 0) begin
      chk("out_opcode", {27'd0, out_opcode}, {27'd0, q[0].op});
      chk("out_pc", {16'd0, out_pc}, {16'd0, q[0].pc});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
    end
    model_encode(c, op, il);
    if (v && sz == DEPTH && m_drop < CMAX) m_drop++;
    if (sz != 0 && r) void'(q.pop_front());
    if (v && sz < DEPTH) begin
      q.push_back('{op: op, pc: p, ill: il});
      if (il && m_ill < CMAX) m_ill++;
    end
    if (clr) begin
      m_drop = 0;
      m_ill = 0;
    end
    @(posedge clk);
    #1;
    chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
    chk("illegal_cnt", {24'd0, illegal_cnt}, m_ill);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_opcode", {27'd0, out_opcode}, 0);
    chk("rst_out_pc", {16'd0, out_pc}, 0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 0);
    chk("rst_illegal_cnt", {24'd0, illegal_cnt}, 0);
    q.delete();
    m_drop = 0;
    m_ill = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_pc = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    add(-1, 4'b0000, 5'b00000); add(4, 4'b0000, 5'b01111); add(5, 4'b0000, 5'b01110);
    add(6, 4'b0000, 5'b01101);  add(7, 4'b0001, 5'b01000); add(8, 4'b0001, 5'b01001);
    add(9, 4'b0001, 5'b01010);  add(10, 4'b0001, 5'b01011); add(11, 4'b0010, 5'b01100);
    add(12, 4'b0100, 5'b00111); add(13, 4'b1000, 5'b11010); add(14, 4'b1100, 5'b00110);
    add(15, 4'b0010, 5'b00101); add(16, 4'b1000, 5'b11001); add(17, 4'b1000, 5'b11000);
    add(18, 4'b1000, 5'b10111); add(19, 4'b1000, 5'b10110); add(20, 4'b1000, 5'b10101);
    add(21, 4'b1000, 5'b10011); add(22, 4'b1000, 5'b10010); add(23, 4'b1000, 5'b00100);
    add(24, 4'b0000, 5'b00011); add(25, 4'b1000, 5'b10001); add(26, 4'b1000, 5'b10000);
    add(27, 4'b1000, 5'b10100); add(28, 4'b0000, 5'b00010); add(29, 4'b0000, 5'b00001);

    @(posedge clk);
    #1;
    do_reset();

    // Sweep every canonical vector back to back with the consumer always ready.
    for (int i = 0; i < ntab; i++) step(1'b1, ctab[i], 16'h1000 + 16'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

    // JMP pattern missing its branch bit.
    step(1'b1, 30'h0000_0080, 16'h2000, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("illegal_cnt_one", {24'd0, illegal_cnt}, 1);

    // Ten ADDs into a stalled FIFO, then pop+push while full.
    for (int i = 0; i < 10; i++) step(1'b1, 30'h0020_0008, 16'h3000 + 16'(i), 1'b0, 1'b0);
    chk("drop_after_fill", {24'd0, drop_cnt}, 2);
    step(1'b1, 30'h0040_0008, 16'h3100, 1'b1, 1'b0);
    chk("drop_full_pop_push", {24'd0, drop_cnt}, 3);
    repeat (9) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Saturate the drop counter, then clear it while another drop occurs.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 30'h0400_0008, 16'h4000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 30'h0000_0010, 16'h5000, 1'b0, 1'b0);
    chk("drop_saturated", {24'd0, drop_cnt}, CMAX);
    step(1'b1, 30'h0000_0010, 16'h5001, 1'b0, 1'b1);
    chk("drop_cleared", {24'd0, drop_cnt}, 0);
    repeat (DEPTH + 1) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset with five entries queued, then confirm a fresh push appears a cycle later.
    for (int i = 0; i < 5; i++) step(1'b1, 30'h3FFF_FFFF, 16'h6000 + 16'(i), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 30'h0100_0000, 16'h7000, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
